// File: rtl/fetch_pkg.sv
// Shared IF-stage types and constants.
// Imported by fetch_stage and if_id_reg.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       32'h0,
    pc_plus4: 32'h0,
    valid:    1'b0
  };

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Priority: rst > flush (bubble) > stall (hold) > load.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   stall,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= IF_ID_BUBBLE;
    end else if (flush) begin
      q <= IF_ID_BUBBLE;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, IF/ID capture, fetch counter.
// Optional FETCH_MISALIGN_CHK_EN adds target alignment and MisalignD.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcE,
  input  logic [31:0]      PCTargetE,
  input  logic [31:0]      InstrF,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic             MisalignD,
`endif
  output logic [CNT_W-1:0] FetchCount
);

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] pc_next;
  logic        load;
  if_id_t      if_d;
  if_id_t      if_q;

  assign pc_plus4 = PCF + 32'd4;

`ifdef FETCH_MISALIGN_CHK_EN
  assign target = {PCTargetE[31:2], 2'b00};
`else
  assign target = PCTargetE;
`endif

  // A redirect must not be lost behind a stall.
  always_comb begin
    pc_next = pc_plus4;
    if (PCSrcE) begin
      pc_next = target;
    end else if (StallF) begin
      pc_next = PCF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PCF <= RESET_PC;
    end else begin
      PCF <= pc_next;
    end
  end

  assign if_d = '{
    instr:    InstrF,
    pc:       PCF,
    pc_plus4: pc_plus4,
    valid:    1'b1
  };

  if_id_reg u_if_id (
    .clk   (clk),
    .rst   (rst),
    .flush (FlushD),
    .stall (StallD),
    .d     (if_d),
    .q     (if_q)
  );

  assign InstrD   = if_q.instr;
  assign PCD      = if_q.pc;
  assign PCPlus4D = if_q.pc_plus4;
  assign ValidD   = if_q.valid;

  assign load = !FlushD && !StallD;

  always_ff @(posedge clk) begin
    if (rst) begin
      FetchCount <= '0;
    end else if (load) begin
      FetchCount <= FetchCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // pend marks that the next decode load is the redirect target.
  logic pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      MisalignD <= 1'b0;
    end else begin
      if (PCSrcE) begin
        pend <= |PCTargetE[1:0];
      end else if (load) begin
        pend <= 1'b0;
      end
      if (FlushD) begin
        MisalignD <= 1'b0;
      end else if (!StallD) begin
        MisalignD <= pend;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, wrap sequence,
// and constrained-random run against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] pc_tgt = 32'h0;
  logic [31:0] instr_f;
  logic [31:0] instr_f4;
  logic [31:0] pcf, instr_d, pcd, pc4d;
  logic        valid_d;
  logic [31:0] cnt;
  logic [31:0] pcf4, instr_d4, pcd4, pc4d4;
  logic        valid_d4;
  logic [3:0]  cnt4;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h9E37_79B9;
  endfunction

  assign instr_f  = imem(pcf);
  assign instr_f4 = imem(pcf4);

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (stall_f),
    .StallD     (stall_d),
    .FlushD     (flush_d),
    .PCSrcE     (pc_src),
    .PCTargetE  (pc_tgt),
    .InstrF     (instr_f),
    .PCF        (pcf),
    .InstrD     (instr_d),
    .PCD        (pcd),
    .PCPlus4D   (pc4d),
    .ValidD     (valid_d),
    .FetchCount (cnt)
  );

  fetch_stage #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .StallF     (stall_f),
    .StallD     (stall_d),
    .FlushD     (flush_d),
    .PCSrcE     (pc_src),
    .PCTargetE  (pc_tgt),
    .InstrF     (instr_f4),
    .PCF        (pcf4),
    .InstrD     (instr_d4),
    .PCD        (pcd4),
    .PCPlus4D   (pc4d4),
    .ValidD     (valid_d4),
    .FetchCount (cnt4)
  );

  // behavioural reference
  logic [31:0] m_pc, m_instr, m_pcd, m_p4;
  logic        m_v;
  int unsigned m_cnt;

  task automatic model_step();
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0;
      m_p4 = 0; m_v = 0; m_cnt = 0;
    end else begin
      if (flush_d) begin
        m_instr = 32'h13; m_pcd = 0; m_p4 = 0; m_v = 0;
      end else if (!stall_d) begin
        m_instr = imem(old_pc); m_pcd = old_pc;
        m_p4 = old_pc + 32'd4; m_v = 1; m_cnt++;
      end
      if (pc_src) m_pc = pc_tgt;
      else if (!stall_f) m_pc = old_pc + 32'd4;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, sf, sd, fd, ps,
                       input logic [31:0] tgt);
    rst = r; stall_f = sf; stall_d = sd;
    flush_d = fd; pc_src = ps; pc_tgt = tgt;
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r, sf, sd, fd, ps;
    logic [31:0] tgt, pcf, pcd;
    logic        v;
    int          cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, sf, sd, fd, ps,
                     input logic [31:0] tgt, epcf, epcd,
                     input logic v, input int c);
    vq.push_back('{r, sf, sd, fd, ps, tgt, epcf, epcd, v, c});
  endtask

  initial begin
    vec_t        t;
    logic [31:0] ei, e4;
    logic [3:0]  c4;
    logic        r, sf, sd, fd, ps;
    logic [31:0] tg;

    add(1,0,0,0,0, 0,           32'h0,  32'h0, 0, 0);
    add(0,0,0,0,0, 0,           32'h4,  32'h0, 1, 1);
    add(0,0,0,0,0, 0,           32'h8,  32'h4, 1, 2);
    add(0,1,1,0,0, 0,           32'h8,  32'h4, 1, 2);
    add(0,1,1,0,0, 0,           32'h8,  32'h4, 1, 2);
    add(0,0,0,0,0, 0,           32'hC,  32'h8, 1, 3);
    add(0,0,0,0,0, 0,           32'h10, 32'hC, 1, 4);
    add(0,0,0,1,1, 32'h40,      32'h40, 32'h0, 0, 4);
    add(0,0,0,0,0, 0,           32'h44, 32'h40, 1, 5);
    add(0,1,1,0,1, 32'h80,      32'h80, 32'h40, 1, 5);
    add(0,0,1,1,0, 0,           32'h84, 32'h0, 0, 5);
    add(0,0,0,1,1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 0, 5);
    add(0,0,0,0,0, 0,           32'h0,  32'hFFFF_FFFC, 1, 6);
    add(0,0,0,0,0, 0,           32'h4,  32'h0, 1, 7);
    add(1,0,0,0,1, 32'h200,     32'h0,  32'h0, 0, 0);
    add(0,0,0,0,0, 0,           32'h4,  32'h0, 1, 1);

    foreach (vq[i]) begin
      t = vq[i];
      drive(t.r, t.sf, t.sd, t.fd, t.ps, t.tgt);
      ei = t.v ? imem(t.pcd) : 32'h13;
      e4 = t.v ? t.pcd + 32'd4 : 32'h0;
      c4 = t.cnt[3:0];
      chk($sformatf("vec%0d_pcf", i), pcf, t.pcf);
      chk($sformatf("vec%0d_pcd", i), pcd, t.pcd);
      chk($sformatf("vec%0d_valid", i), {31'b0, valid_d}, {31'b0, t.v});
      chk($sformatf("vec%0d_instr", i), instr_d, ei);
      chk($sformatf("vec%0d_pc4", i), pc4d, e4);
      chk($sformatf("vec%0d_cnt", i), cnt, t.cnt);
      chk($sformatf("vec%0d_cnt4", i), {28'b0, cnt4}, {28'b0, c4});
    end

    // 4-bit counter wraps after 16 loads
    drive(1,0,0,0,0, 0);
    for (int k = 0; k < 17; k++) drive(0,0,0,0,0, 0);
    chk("wrap17_cnt4", {28'b0, cnt4}, 32'd1);
    chk("wrap17_cnt", cnt, 32'd17);
    chk("wrap17_pcf", pcf, 32'd68);

    // constrained-random run
    drive(1,0,0,0,0, 0);
    for (int k = 0; k < 400; k++) begin
      r  = ($urandom_range(0, 59) == 0);
      ps = ($urandom_range(0, 7) == 0);
      fd = ps || ($urandom_range(0, 11) == 0);
      sf = ($urandom_range(0, 4) == 0);
      sd = sf || ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 2))
        0: tg = $urandom & 32'hFFFF_FFFC;
        1: tg = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        default: tg = $urandom;
      endcase
      drive(r, sf, sd, fd, ps, tg);
      chk($sformatf("rnd%0d_pcf", k), pcf, m_pc);
      chk($sformatf("rnd%0d_instr", k), instr_d, m_instr);
      chk($sformatf("rnd%0d_pcd", k), pcd, m_pcd);
      chk($sformatf("rnd%0d_pc4", k), pc4d, m_p4);
      chk($sformatf("rnd%0d_valid", k), {31'b0, valid_d}, {31'b0, m_v});
      chk($sformatf("rnd%0d_cnt", k), cnt, m_cnt);
      chk($sformatf("rnd%0d_cnt4", k), {28'b0, cnt4},
          {28'b0, m_cnt[3:0]});
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
